// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_pkg;

  // Default build widths; the FIFO data width and DATA_W must match.
  localparam int FIFO_RD_DATA_W     = 8;
  localparam int FIFO_RD_LEN_W      = 8;
  localparam int FIFO_RD_OBUF_DEPTH = 3;
  localparam int FIFO_RD_STALL_W    = 16;

  // Transfer controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } fifo_rd_state_t;

  // Width of an occupancy counter that must reach 'depth' itself.
  function automatic int fifo_rd_occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream byte stream, bundled for the reader.
// Latency: n/a (wiring only); fifo_dout is valid one cycle after fifo_rd_en.
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
interface fifo_stream_reader_if #(
  parameter int DATA_W = fifo_rd_pkg::FIFO_RD_DATA_W
);
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  // The reader: pops the FIFO and sources the stream.
  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last
  );

  // The surroundings: FIFO read side and the stream consumer.
  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last
  );
endinterface

// File: rtl/fifo_rd_obuf.sv
// Small circular output buffer with explicit pointer wrap (any depth >= 2).
// Latency: push visible at the head one cycle later; pop frees the entry at the next edge.
// Backpressure: none internally; the caller must not push into a full buffer.
module fifo_rd_obuf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = FIFO_RD_DATA_W,
  parameter int DEPTH  = FIFO_RD_OBUF_DEPTH,
  localparam int OCC_W = fifo_rd_occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_pop;

  // Next-state for storage, pointers and occupancy; pointers wrap at DEPTH-1.
  always_comb begin
    do_pop = pop && (occ_q != '0);
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end
    if (do_pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (push && !do_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && do_pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Register update; reset empties the buffer and clears the entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

  // The read-issue rule reserves a slot for every in-flight byte, so a push
  // into a full buffer without a matching pop means that rule is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !do_pop && (occ_q == FULL_OCC)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains 'len' bytes from a registered-output FIFO onto a valid/ready stream with last.
// Latency: start -> first rd_en 1 cycle, -> first m_valid 3 cycles; 1 byte/cycle with OBUF_DEPTH >= 3.
// Backpressure: m_ready low stops pops once the output buffer plus in-flight read is full.
// Optional build macro FIFO_RD_STATS_EN adds the stall_cnt output.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = FIFO_RD_DATA_W,
  parameter int LEN_W      = FIFO_RD_LEN_W,
  parameter int OBUF_DEPTH = FIFO_RD_OBUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [FIFO_RD_STALL_W-1:0] stall_cnt
`endif
);

  localparam int OCC_W = fifo_rd_occ_w(OBUF_DEPTH);
  localparam logic [OCC_W:0] OBUF_LIM = (OCC_W + 1)'(OBUF_DEPTH);

  // Two entries is the smallest buffer that can ever make progress.
  if (OBUF_DEPTH < 2) begin : g_depth_check
    $error("fifo_stream_reader: OBUF_DEPTH must be at least 2");
  end

  fifo_rd_state_t    state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_W-1:0]  out_rem_q, out_rem_d;
  logic              inflight_q, inflight_d;

  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] head_data;
  logic              rd_en;
  logic              out_vld;
  logic              out_last;
  logic              out_hs;

  // Output buffer: captures the FIFO's registered data the cycle after each pop.
  fifo_rd_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (bus.fifo_dout),
    .pop       (out_hs),
    .occ       (occ),
    .head_data (head_data)
  );

  // Read issue and stream flags; rd_en uses only registered terms and the
  // FIFO flag so m_ready never reaches the pop strobe combinationally.
  always_comb begin
    rd_en = (state_q == XFER) && !bus.fifo_empty && (issue_rem_q != '0) &&
            (({1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}) < OBUF_LIM);
    out_vld  = (occ != '0);
    out_last = out_vld && (out_rem_q == LEN_W'(1));
    out_hs   = out_vld && bus.m_ready;
  end

  // Controller next-state: transfer FSM, remaining-byte counters, read tracking.
  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero-length request completes without touching the FIFO.
          state_d     = (len == '0) ? DONE : XFER;
          issue_rem_d = len;
          out_rem_d   = len;
        end
      end
      XFER: begin
        if (out_hs && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // rd_en and handshakes only occur in XFER, never alongside the IDLE load.
    if (rd_en) begin
      issue_rem_d = issue_rem_q - LEN_W'(1);
    end
    if (out_hs) begin
      out_rem_d = out_rem_q - LEN_W'(1);
    end
    busy_d     = (state_d == XFER);
    done_d     = (state_d == DONE);
    inflight_d = rd_en;
  end

  // Controller registers; reset drops the transfer and any in-flight byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      inflight_q  <= inflight_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = out_vld;
  assign bus.m_data     = head_data;
  assign bus.m_last     = out_last;

  // A read is only ever issued when the controller is moving bytes.
  a_inflight_in_xfer: assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && (state_q != XFER)));

`ifdef FIFO_RD_STATS_EN
  logic [FIFO_RD_STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Starvation counter: XFER cycles spent waiting on an empty FIFO, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == XFER) && bus.fifo_empty && (issue_rem_q != '0) &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + FIFO_RD_STALL_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 8-entry FIFO.
// Latency: n/a.
// Backpressure: m_ready driven from the stimulus.
module tb_fifo_stream_reader;
  import fifo_rd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       busy, done;
  logic       m_ready = 1'b1;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(FIFO_RD_DATA_W)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_stream_reader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Behavioural 8-entry FIFO with registered read data.
  logic [7:0] fmem [8];
  logic [2:0] fwr = 3'd0, frd = 3'd0;
  logic [3:0] fcnt = 4'd0;
  logic [7:0] fdout = 8'd0;
  logic       wr_en = 1'b0, fclr = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       underflow = 1'b0;
  int         rd_pulses = 0;

  always @(posedge clk) begin
    if (fclr) begin
      fwr  <= 3'd0;
      frd  <= 3'd0;
      fcnt <= 4'd0;
    end else begin
      if (bus.fifo_rd_en) begin
        fdout <= fmem[frd];
        frd   <= frd + 3'd1;
      end
      if (wr_en) begin
        fmem[fwr] <= wr_data;
        fwr       <= fwr + 3'd1;
      end
      fcnt <= fcnt + {3'b0, wr_en} - {3'b0, bus.fifo_rd_en};
    end
    if (bus.fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (bus.fifo_rd_en && fcnt == 4'd0) underflow <= 1'b1;
  end

  assign bus.fifo_empty = (fcnt == 4'd0);
  assign bus.fifo_dout  = fdout;
  assign bus.m_ready    = m_ready;

  int n_chk = 0, n_pass = 0;
  int base_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Collects n stream bytes base, base+1, ... until done, within a cycle budget.
  task automatic collect(input int n, input logic [7:0] base, input string nm);
    int   got = 0;
    logic seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        chk($sformatf("%s.data%0d", nm, got), 32'(bus.m_data), 32'(base) + got);
        chk($sformatf("%s.last%0d", nm, got), 32'(bus.m_last), 32'(got == n - 1));
        got++;
      end
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk($sformatf("%s.count", nm), 32'(got), 32'(n));
    chk($sformatf("%s.done", nm), 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       valid;
    logic       last;
    logic [7:0] data;
  } vec_t;

  vec_t vt [12];

  initial begin
    // len=5 transfer of 0x11..0x15, then a len=0 request (m_ready held high).
    vt[0]  = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
    vt[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12};
    vt[5]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h13};
    vt[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h14};
    vt[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15};
    vt[8]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[10] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[11] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.done",  32'(done), 32'd0);
    chk("rst.rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst.valid", 32'(bus.m_valid), 32'd0);
    chk("rst.last",  32'(bus.m_last), 32'd0);
    chk("rst.data",  32'(bus.m_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("rst.stall", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven basic transfer and zero-length request.
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    base_rd = rd_pulses;
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start;
      len   = vt[i].len;
      @(negedge clk);
      chk($sformatf("v%0d.busy", i),  32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d.done", i),  32'(done), 32'(vt[i].done));
      chk($sformatf("v%0d.rd_en", i), 32'(bus.fifo_rd_en), 32'(vt[i].rd_en));
      chk($sformatf("v%0d.valid", i), 32'(bus.m_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d.last", i),  32'(bus.m_last), 32'(vt[i].last));
      if (vt[i].valid) chk($sformatf("v%0d.data", i), 32'(bus.m_data), 32'(vt[i].data));
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("basic.pops", 32'(rd_pulses - base_rd), 32'd5);

    // Backpressure: 8 bytes, m_ready low for 10 cycles.
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    base_rd = rd_pulses;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      start = (cyc == 0);
      len   = 8'd8;
      @(negedge clk);
      if (cyc >= 3) begin
        chk($sformatf("bp.valid%0d", cyc), 32'(bus.m_valid), 32'd1);
        chk($sformatf("bp.data%0d", cyc),  32'(bus.m_data), 32'h30);
      end
      if (cyc == 9) begin
        chk("bp.pops_stalled", 32'(rd_pulses - base_rd), 32'(FIFO_RD_OBUF_DEPTH));
        chk("bp.rd_en_stalled", 32'(bus.fifo_rd_en), 32'd0);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    m_ready = 1'b1;
    collect(8, 8'h30, "bp");
    chk("bp.pops", 32'(rd_pulses - base_rd), 32'd8);

    // Starved FIFO: bytes arrive 5 cycles apart, each popped on arrival.
    base_rd = rd_pulses;
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      wr_en   = (cyc == 2 || cyc == 7 || cyc == 12);
      wr_data = (cyc == 2) ? 8'hA0 : (cyc == 7) ? 8'hA1 : 8'hA2;
      @(negedge clk);
      chk($sformatf("st.rd_en%0d", cyc), 32'(bus.fifo_rd_en), 32'(cyc == 3 || cyc == 8 || cyc == 13));
      chk($sformatf("st.valid%0d", cyc), 32'(bus.m_valid), 32'(cyc == 5 || cyc == 10 || cyc == 15));
      chk($sformatf("st.last%0d", cyc),  32'(bus.m_last), 32'(cyc == 15));
      chk($sformatf("st.done%0d", cyc),  32'(done), 32'(cyc == 16));
      if (cyc == 5)  chk("st.data0", 32'(bus.m_data), 32'hA0);
      if (cyc == 10) chk("st.data1", 32'(bus.m_data), 32'hA1);
      if (cyc == 15) chk("st.data2", 32'(bus.m_data), 32'hA2);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    chk("st.pops", 32'(rd_pulses - base_rd), 32'd3);
`ifdef FIFO_RD_STATS_EN
    chk("st.stall_cnt", 32'(stall_cnt), 32'd10);
`endif

    // Reset after two of six bytes delivered.
    for (int i = 0; i < 8; i++) push_byte(8'h50 + 8'(i));
    base_rd = rd_pulses;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      start   = (cyc == 0);
      len     = 8'd6;
      reset   = (cyc == 5);
      m_ready = (cyc != 5);
      @(negedge clk);
      if (cyc == 3) chk("rm.data0", 32'(bus.m_data), 32'h50);
      if (cyc == 4) chk("rm.data1", 32'(bus.m_data), 32'h51);
      if (cyc == 6) begin
        chk("rm.busy",  32'(busy), 32'd0);
        chk("rm.done",  32'(done), 32'd0);
        chk("rm.rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rm.valid", 32'(bus.m_valid), 32'd0);
        chk("rm.last",  32'(bus.m_last), 32'd0);
        chk("rm.data",  32'(bus.m_data), 32'd0);
        chk("rm.pops",  32'(rd_pulses - base_rd), 32'd5);
`ifdef FIFO_RD_STATS_EN
        chk("rm.stall", 32'(stall_cnt), 32'd0);
`endif
      end
      @(posedge clk); #1;
    end
    start = 1'b1;
    len   = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    collect(2, 8'h55, "rm2");
    fclr = 1'b1;
    @(posedge clk); #1;
    fclr = 1'b0;

    // start during XFER (len=9) must not disturb a len=4 transfer.
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
    base_rd = rd_pulses;
    for (int cyc = 0; cyc < 3; cyc++) begin
      start = (cyc == 0 || cyc == 2);
      len   = (cyc == 0) ? 8'd4 : 8'd9;
      @(negedge clk);
      if (cyc == 2) chk("ig.busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    len   = 8'd0;
    collect(4, 8'h60, "ig");
    chk("ig.pops", 32'(rd_pulses - base_rd), 32'd4);
    @(negedge clk);
    chk("ig.idle_busy", 32'(busy), 32'd0);
    chk("ig.idle_done", 32'(done), 32'd0);

    chk("fifo.underflow", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Run-length guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
